// File: rtl/i2s_slave_rx_if.sv
`timescale 1ns/1ps
// i2s_slave_rx_if
//   Bundles the I2S pin-side inputs, the receive enable and the parallel
//   word outputs of the I2S slave receiver.
//   master modport : the side that drives en/BCLK/LRCLK/SDATA and consumes words
//   slave modport  : the receiver itself (i2s_slave_rx)
//   Signals:
//     en          receive enable (clk domain)
//     BCLK        I2S bit clock (asynchronous to clk)
//     LRCLK       I2S word select, 0 = left, 1 = right (asynchronous)
//     SDATA       I2S serial data, MSB first (asynchronous)
//     left_data   last complete left word
//     right_data  last complete right word
//     left_valid  1-clk pulse, left_data updated
//     right_valid 1-clk pulse, right_data updated
//     frame_valid 1-clk pulse with right_valid when the left word of the frame completed
//     short_word  1-clk pulse with a *_valid when the slot was shorter than DATA_WIDTH
//     synced      high once the first LRCLK transition was seen after reset/enable
interface i2s_slave_rx_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  en;
  logic                  BCLK;
  logic                  LRCLK;
  logic                  SDATA;
  logic [DATA_WIDTH-1:0] left_data;
  logic [DATA_WIDTH-1:0] right_data;
  logic                  left_valid;
  logic                  right_valid;
  logic                  frame_valid;
  logic                  short_word;
  logic                  synced;

  modport master (
    output en, BCLK, LRCLK, SDATA,
    input  left_data, right_data, left_valid, right_valid,
           frame_valid, short_word, synced
  );

  modport slave (
    input  en, BCLK, LRCLK, SDATA,
    output left_data, right_data, left_valid, right_valid,
           frame_valid, short_word, synced
  );
endinterface

// File: rtl/i2s_slave_rx.sv
`timescale 1ns/1ps
// i2s_slave_rx
//   Philips-format I2S slave receiver. BCLK, LRCLK and SDATA are oversampled
//   with clk through 2-flop synchronizers; only rising BCLK edges are used.
//   Serial bits are collected MSB first into a left-justified shift register
//   and handed out as parallel left/right words in the clk domain.
//   Ports:
//     clk  system clock, f_clk >= 4 * f_BCLK
//     rst  asynchronous, active-high reset
//     bus  i2s_slave_rx_if.slave (pins, enable, words and status pulses)
module i2s_slave_rx #(
  parameter int DATA_WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  i2s_slave_rx_if.slave  bus
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_WIDTH);

  // synchronizer chains; bclk_d_r is the extra stage for edge detection
  logic bclk_meta_r, bclk_sync_r, bclk_d_r;
  logic ws_meta_r, ws_sync_r;
  logic sd_meta_r, sd_sync_r;
  logic bclk_rise_s;

  // receive state
  logic [DATA_WIDTH-1:0] shreg_r, shreg_nxt_s, shreg_w_s;
  logic [CNT_W-1:0]      cnt_r, cnt_nxt_s, cnt_inc_s;
  logic                  ws_prev_r, ws_prev_nxt_s;
  logic                  synced_r, synced_nxt_s;
  logic                  l_done_r, l_done_nxt_s;

  // registered outputs
  logic [DATA_WIDTH-1:0] left_data_r, left_data_nxt_s;
  logic [DATA_WIDTH-1:0] right_data_r, right_data_nxt_s;
  logic                  left_valid_r, left_valid_nxt_s;
  logic                  right_valid_r, right_valid_nxt_s;
  logic                  frame_valid_r, frame_valid_nxt_s;
  logic                  short_word_r, short_word_nxt_s;

  // Synchronize the three asynchronous I2S pins into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclk_meta_r <= 1'b0;
      bclk_sync_r <= 1'b0;
      bclk_d_r    <= 1'b0;
      ws_meta_r   <= 1'b0;
      ws_sync_r   <= 1'b0;
      sd_meta_r   <= 1'b0;
      sd_sync_r   <= 1'b0;
    end else begin
      bclk_meta_r <= bus.BCLK;
      bclk_sync_r <= bclk_meta_r;
      bclk_d_r    <= bclk_sync_r;
      ws_meta_r   <= bus.LRCLK;
      ws_sync_r   <= ws_meta_r;
      sd_meta_r   <= bus.SDATA;
      sd_sync_r   <= sd_meta_r;
    end
  end

  assign bclk_rise_s = bclk_sync_r & ~bclk_d_r;

  // Next-state logic: bit capture, word completion and status pulses.
  always_comb begin
    // Bit placement: position DATA_WIDTH-1-cnt; beyond DATA_WIDTH bits the slot is ignored.
    shreg_w_s = shreg_r;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (cnt_r == CNT_W'(DATA_WIDTH - 1 - i)) begin
        shreg_w_s[i] = sd_sync_r;
      end else begin
        shreg_w_s[i] = shreg_r[i];
      end
    end
    if (cnt_r < CNT_FULL) begin
      cnt_inc_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_inc_s = cnt_r;
    end

    shreg_nxt_s       = shreg_r;
    cnt_nxt_s         = cnt_r;
    ws_prev_nxt_s     = ws_prev_r;
    synced_nxt_s      = synced_r;
    l_done_nxt_s      = l_done_r;
    left_data_nxt_s   = left_data_r;
    right_data_nxt_s  = right_data_r;
    left_valid_nxt_s  = 1'b0;
    right_valid_nxt_s = 1'b0;
    frame_valid_nxt_s = 1'b0;
    short_word_nxt_s  = 1'b0;

    if (!bus.en) begin
      // Idle: drop any partial word and require a fresh LRCLK edge to resync.
      shreg_nxt_s  = {DATA_WIDTH{1'b0}};
      cnt_nxt_s    = {CNT_W{1'b0}};
      l_done_nxt_s = 1'b0;
      synced_nxt_s = 1'b0;
    end else if (bclk_rise_s) begin
      if (ws_sync_r == ws_prev_r) begin
        shreg_nxt_s = shreg_w_s;
        cnt_nxt_s   = cnt_inc_s;
      end else begin
        // Word boundary: thanks to the 1-bit I2S delay this bit is the LSB
        // of the word belonging to ws_prev_r.
        if (synced_r) begin
          short_word_nxt_s = (cnt_inc_s < CNT_FULL);
          if (ws_prev_r) begin
            right_data_nxt_s  = shreg_w_s;
            right_valid_nxt_s = 1'b1;
            frame_valid_nxt_s = l_done_r;
            l_done_nxt_s      = 1'b0;
          end else begin
            left_data_nxt_s  = shreg_w_s;
            left_valid_nxt_s = 1'b1;
            l_done_nxt_s     = 1'b1;
          end
        end else begin
          // First edge after reset/enable: the partial word is discarded.
          l_done_nxt_s = 1'b0;
        end
        shreg_nxt_s   = {DATA_WIDTH{1'b0}};
        cnt_nxt_s     = {CNT_W{1'b0}};
        ws_prev_nxt_s = ws_sync_r;
        synced_nxt_s  = 1'b1;
      end
    end else begin
      shreg_nxt_s = shreg_r;
      cnt_nxt_s   = cnt_r;
    end
  end

  // Receive state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_r       <= {DATA_WIDTH{1'b0}};
      cnt_r         <= {CNT_W{1'b0}};
      ws_prev_r     <= 1'b0;
      synced_r      <= 1'b0;
      l_done_r      <= 1'b0;
      left_data_r   <= {DATA_WIDTH{1'b0}};
      right_data_r  <= {DATA_WIDTH{1'b0}};
      left_valid_r  <= 1'b0;
      right_valid_r <= 1'b0;
      frame_valid_r <= 1'b0;
      short_word_r  <= 1'b0;
    end else begin
      shreg_r       <= shreg_nxt_s;
      cnt_r         <= cnt_nxt_s;
      ws_prev_r     <= ws_prev_nxt_s;
      synced_r      <= synced_nxt_s;
      l_done_r      <= l_done_nxt_s;
      left_data_r   <= left_data_nxt_s;
      right_data_r  <= right_data_nxt_s;
      left_valid_r  <= left_valid_nxt_s;
      right_valid_r <= right_valid_nxt_s;
      frame_valid_r <= frame_valid_nxt_s;
      short_word_r  <= short_word_nxt_s;
    end
  end

  assign bus.left_data   = left_data_r;
  assign bus.right_data  = right_data_r;
  assign bus.left_valid  = left_valid_r;
  assign bus.right_valid = right_valid_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.short_word  = short_word_r;
  assign bus.synced      = synced_r;

endmodule

// File: tb/tb_i2s_slave_rx.sv
`timescale 1ns/1ps
// tb_i2s_slave_rx
//   Drives an I2S master model into i2s_slave_rx and checks every delivered
//   word against a scoreboard queue filled as the words are transmitted.
module tb_i2s_slave_rx;

  localparam int  DW   = 16;
  localparam time HALF = 200ns;   // half BCLK period (40 clk per bit)

  typedef struct {
    bit          ch;      // 0 = left, 1 = right
    logic [15:0] data;
    bit          short_w;
    bit          frame;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  i2s_slave_rx_if #(.DATA_WIDTH(DW)) bus ();

  i2s_slave_rx #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_left_data"},  {16'h0, bus.left_data},  32'h0);
    check_eq({tag, "_right_data"}, {16'h0, bus.right_data}, 32'h0);
    check_eq({tag, "_pulses"}, {28'h0, bus.left_valid, bus.right_valid,
                                bus.frame_valid, bus.short_word}, 32'h0);
    check_eq({tag, "_synced"}, {31'h0, bus.synced}, 32'h0);
  endtask

  // One BCLK period: pins change while BCLK is low, receiver samples on the rise.
  task automatic send_bit(input logic ws, input logic sd, input bit do_rst);
    bus.LRCLK = ws;
    bus.SDATA = sd;
    if (do_rst) begin
      #50;
      rst = 1'b1;
      #7;
      check_all_zero("rst_mid_word");
      #50;
      rst = 1'b0;
      #(HALF - 107);
    end else begin
      #HALF;
    end
    bus.BCLK = 1'b1;
    #HALF;
    bus.BCLK = 1'b0;
  endtask

  // One channel slot. LRCLK leads the data by one bit, so the last bit of a
  // slot already carries the next channel's word select.
  task automatic send_word(input bit ch, input logic [31:0] data, input int nbits,
                           input bit exp_v, input bit exp_f,
                           input int en_drop_at, input int rst_at);
    logic [31:0] just;
    exp_t e;
    just = data << (32 - nbits);
    if (exp_v) begin
      e.ch      = ch;
      e.data    = just[31:16];
      e.short_w = (nbits < DW);
      e.frame   = exp_f;
      sb_q.push_back(e);
    end
    for (int i = 0; i < nbits; i++) begin
      if (i == en_drop_at) begin
        bus.en = 1'b0;
        #100;
        check_eq("synced_en_low", {31'h0, bus.synced}, 32'h0);
      end
      if (i == en_drop_at + 2) begin
        bus.en = 1'b1;
      end
      send_bit((i == nbits - 1) ? ~ch : ch, data[nbits-1-i], (i == rst_at));
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nbits,
                            input bit exp_l, input bit exp_r, input bit exp_f);
    send_word(1'b0, l, nbits, exp_l, 1'b0, -1, -1);
    send_word(1'b1, r, nbits, exp_r, exp_f, -1, -1);
  endtask

  // Scoreboard: every valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.left_valid && bus.right_valid) begin
        check_eq("both_valid", 32'h1, 32'h0);
      end else if (bus.left_valid || bus.right_valid) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_valid", {31'h0, bus.right_valid}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("channel", {31'h0, bus.right_valid}, {31'h0, e.ch});
          check_eq("data", {16'h0, (e.ch ? bus.right_data : bus.left_data)}, {16'h0, e.data});
          check_eq("short_word", {31'h0, bus.short_word}, {31'h0, e.short_w});
          check_eq("frame_valid", {31'h0, bus.frame_valid}, {31'h0, e.frame});
        end
      end else if (bus.frame_valid || bus.short_word) begin
        check_eq("stray_pulse", {30'h0, bus.frame_valid, bus.short_word}, 32'h0);
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.en    = 1'b0;
    bus.BCLK  = 1'b0;
    bus.LRCLK = 1'b0;
    bus.SDATA = 1'b0;
    #100;
    check_all_zero("reset");
    rst = 1'b0;
    #100;
    bus.en = 1'b1;

    // 1: continuous stream; first left word is dropped, first right has no frame
    send_frame(32'hA5C3, 32'h1234, 16, 1'b0, 1'b1, 1'b0);
    send_frame(32'hA5C3, 32'h1234, 16, 1'b1, 1'b1, 1'b1);
    send_frame(32'hA5C3, 32'h1234, 16, 1'b1, 1'b1, 1'b1);
    #1000;
    check_eq("synced_stream", {31'h0, bus.synced}, 32'h1);
    check_eq("hold_left",  {16'h0, bus.left_data},  32'hA5C3);
    check_eq("hold_right", {16'h0, bus.right_data}, 32'h1234);

    // 2: 24-bit slots, extra LSBs dropped
    send_frame(32'hABCDEF, 32'h123456, 24, 1'b1, 1'b1, 1'b1);

    // 3: 8-bit and 1-bit slots, zero-padded with short_word
    send_frame(32'h9F, 32'h3C, 8, 1'b1, 1'b1, 1'b1);
    send_frame(32'h1, 32'h0, 1, 1'b1, 1'b1, 1'b1);

    // 4: en dropped mid right word; resync on its trailing LRCLK edge
    send_word(1'b0, 32'h5A5A, 16, 1'b1, 1'b0, -1, -1);
    send_word(1'b1, 32'hDEAD, 16, 1'b0, 1'b0, 6, -1);
    send_word(1'b0, 32'h0F0F, 16, 1'b1, 1'b0, -1, -1);
    send_word(1'b1, 32'hBEEF, 16, 1'b1, 1'b1, -1, -1);

    // 5: async reset mid left word; that word is lost, right arrives without frame
    send_word(1'b0, 32'h1357, 16, 1'b0, 1'b0, -1, 5);
    send_word(1'b1, 32'h2468, 16, 1'b1, 1'b0, -1, -1);
    send_frame(32'hC0DE, 32'hFACE, 16, 1'b1, 1'b1, 1'b1);

    // 6: loopback-style {sw,sw} patterns
    send_frame(32'h0000, 32'h0000, 16, 1'b1, 1'b1, 1'b1);
    send_frame(32'hFFFF, 32'hFFFF, 16, 1'b1, 1'b1, 1'b1);
    send_frame(32'h8001, 32'h8001, 16, 1'b1, 1'b1, 1'b1);

    #2000;
    check_eq("sb_drain", sb_q.size(), 32'h0);
    check_eq("final_left",  {16'h0, bus.left_data},  32'h8001);
    check_eq("final_right", {16'h0, bus.right_data}, 32'h8001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
